decode_stage: RTL and testbench
===============================

Name: decode_stage

Overview:
- Decode stage of the core; sits between fetch and execute, directly upstream of the register file.
- Accepts fetched instructions over a valid/ready handshake and drives the register file read addresses.
- Registers decoded fields and immediate so they align with the register file's 1-cycle synchronous read data.
- Stalls on load-use hazards until forwarded write data has landed on the read ports.

Parameters:
- XLEN, 32, datapath and immediate width.
- REG_ADDR_WIDTH, 5, register address width.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  synchronous, active-low reset (asserted when 0).
- fetch_valid  in  1  fetch presents an instruction.
- fetch_instruction  in  32  raw RV32I instruction.
- fetch_pc  in  XLEN  PC of fetch_instruction.
- fetch_ready  out  1  decode accepts this cycle.
- register_read_address_a  out  REG_ADDR_WIDTH  rs1 to register file.
- register_read_address_b  out  REG_ADDR_WIDTH  rs2 to register file.
- ex_load_pending  in  1  a load is in flight beyond decode and has not yet presented its write.
- ex_load_rd  in  REG_ADDR_WIDTH  destination of that load.
- decode_valid  out  1  decoded instruction is valid for execute.
- decode_ready  in  1  execute accepts.
- decode_pc  out  XLEN  PC of slot instruction.
- decode_rd, decode_rs1, decode_rs2  out  REG_ADDR_WIDTH each  register fields.
- decode_funct3  out  3  funct3.
- decode_funct7_bit5  out  1  instruction[30].
- decode_op_class  out  4  op class enum (see package).
- decode_immediate  out  XLEN  sign-extended immediate.
- decode_illegal  out  1  opcode not in RV32I base set.

Behaviour:
- Single output slot: slot_valid plus stored instruction, PC and decoded fields.
- Reset (rst == 0 at edge): slot_valid = 0, hazard_hold_q = 0, all decode_* outputs = 0; fetch_ready = 0 while reset is asserted.
- hazard: slot_valid && ex_load_pending && ex_load_rd != 0 && ((uses_rs1 && ex_load_rd == rs1) || (uses_rs2 && ex_load_rd == rs2)). uses_rs1/uses_rs2 come from the op class. LUI/AUIPC/JAL use neither; I-type, load and JALR use rs1 only.
- hazard_hold_q is registered: set to 1 in any cycle where hazard = 1, otherwise 0. It gives one extra cycle so the register file's write-before-read result reaches register_read_data.
- decode_valid = slot_valid && !hazard && !hazard_hold_q (combinational).
- fetch_ready = rst && (!slot_valid || (decode_valid && decode_ready)).
- accept = fetch_valid && fetch_ready. On accept the slot loads the new instruction and its decoded fields, and slot_valid becomes 1.
- If decode_valid && decode_ready && !fetch_valid, slot_valid becomes 0.
- Read addresses (combinational):
  - On accept: instruction[19:15] and [24:20] of fetch_instruction.
  - Otherwise: rs1/rs2 of the held slot. The register file therefore re-reads every held cycle and picks up writebacks during stalls.
- Register read data from the register file is valid in the cycle after accept and in every cycle while the slot is held; execute samples it alongside decode_* when decode_valid.
- Immediate generation:
  - I: [31:20] sign-extended.
  - S: {[31:25],[11:7]}.
  - B: {[31],[7],[30:25],[11:8],0}.
  - U: {[31:12],12'b0}.
  - J: {[31],[19:12],[20],[30:21],0}.
  - All sign-extended from bit 31; R-type immediate = 0.
- Illegal opcodes: op_class = OP_ILLEGAL, decode_illegal = 1, rd forced to 0. The instruction still flows through the handshake; execute raises the trap.
- Simultaneous events:
  - Output fire and new accept in the same cycle: the slot is replaced with no bubble.
  - hazard and decode_ready in the same cycle: no fire.
  - Reset mid-stall: slot and hazard state clear; the pending instruction is dropped.

Decomposition:
- Shared package core_pkg holds:
  - RV32I opcode constants (OPC_LUI 0110111, OPC_AUIPC, OPC_JAL, OPC_JALR, OPC_BRANCH, OPC_LOAD, OPC_STORE, OPC_OP_IMM, OPC_OP, OPC_FENCE, OPC_SYSTEM).
  - op_class enum: OP_ALU, OP_ALU_IMM, OP_LOAD, OP_STORE, OP_BRANCH, OP_JAL, OP_JALR, OP_LUI, OP_AUIPC, OP_FENCE, OP_SYSTEM, OP_ILLEGAL.
  - Immediate-format enum.
- One combinational sub-module, immediate_generator (instruction, format -> XLEN immediate).

Test Plan:
- Reset then ADDI x5,x1,-3 (0xFFD08293) with fetch_valid=1, decode_ready=1 -> next cycle decode_valid=1, rd=5, rs1=1, immediate=0xFFFFFFFD, op_class=OP_ALU_IMM; register_read_address_a=1 during the accept cycle.
- Back-to-back ADD, SUB, SW with decode_ready=1 -> one instruction per cycle, fetch_ready held 1. SW x2,8(x3) gives immediate=8 and rd=0.
- decode_ready=0 for 3 cycles with the slot full -> fetch_ready=0, outputs and read addresses stable. A register file write to rs1 during the stall is visible on read data the next cycle.
- ex_load_pending=1, ex_load_rd=6, slot holds ADD x7,x6,x2 -> decode_valid=0. Drop pending at cycle N -> decode_valid still 0 at N, 1 at N+1.
- Load-use check with ex_load_rd=0, or LUI x6 in the slot -> no stall.
- Opcode 0x7F -> decode_illegal=1, op_class=OP_ILLEGAL. rst=0 mid-stall -> decode_valid=0 and fetch_ready=0 next cycle.

Source files
------------

// File: rtl/core_pkg.sv
// Shared RV32I definitions: opcodes, op classes, immediate formats and opcode classification.
package core_pkg;

    localparam int unsigned INSTR_WIDTH = 32;

    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_FENCE  = 7'b0001111;
    localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

    typedef enum logic [3:0] {
        OP_ALU     = 4'd0,
        OP_ALU_IMM = 4'd1,
        OP_LOAD    = 4'd2,
        OP_STORE   = 4'd3,
        OP_BRANCH  = 4'd4,
        OP_JAL     = 4'd5,
        OP_JALR    = 4'd6,
        OP_LUI     = 4'd7,
        OP_AUIPC   = 4'd8,
        OP_FENCE   = 4'd9,
        OP_SYSTEM  = 4'd10,
        OP_ILLEGAL = 4'd11
    } op_class_e;

    typedef enum logic [2:0] {
        FMT_R = 3'd0,
        FMT_I = 3'd1,
        FMT_S = 3'd2,
        FMT_B = 3'd3,
        FMT_U = 3'd4,
        FMT_J = 3'd5
    } imm_fmt_e;

    typedef struct packed {
        op_class_e op_class;
        imm_fmt_e  fmt;
        logic      uses_rs1;
        logic      uses_rs2;
        logic      writes_rd;
    } op_info_t;

    // Stores and branches have no destination; their rd field carries immediate bits.
    function automatic op_info_t classify(input logic [6:0] opcode);
        op_info_t info;
        info = '{op_class: OP_ILLEGAL, fmt: FMT_R, uses_rs1: 1'b0, uses_rs2: 1'b0, writes_rd: 1'b0};
        unique case (opcode)
            OPC_OP:     info = '{OP_ALU,     FMT_R, 1'b1, 1'b1, 1'b1};
            OPC_OP_IMM: info = '{OP_ALU_IMM, FMT_I, 1'b1, 1'b0, 1'b1};
            OPC_LOAD:   info = '{OP_LOAD,    FMT_I, 1'b1, 1'b0, 1'b1};
            OPC_STORE:  info = '{OP_STORE,   FMT_S, 1'b1, 1'b1, 1'b0};
            OPC_BRANCH: info = '{OP_BRANCH,  FMT_B, 1'b1, 1'b1, 1'b0};
            OPC_JAL:    info = '{OP_JAL,     FMT_J, 1'b0, 1'b0, 1'b1};
            OPC_JALR:   info = '{OP_JALR,    FMT_I, 1'b1, 1'b0, 1'b1};
            OPC_LUI:    info = '{OP_LUI,     FMT_U, 1'b0, 1'b0, 1'b1};
            OPC_AUIPC:  info = '{OP_AUIPC,   FMT_U, 1'b0, 1'b0, 1'b1};
            OPC_FENCE:  info = '{OP_FENCE,   FMT_I, 1'b0, 1'b0, 1'b1};
            OPC_SYSTEM: info = '{OP_SYSTEM,  FMT_I, 1'b0, 1'b0, 1'b1};
            default:    info = '{OP_ILLEGAL, FMT_R, 1'b0, 1'b0, 1'b0};
        endcase
        return info;
    endfunction

endpackage

// File: rtl/immediate_generator.sv
// Builds the sign-extended immediate for the selected RV32I instruction format.
module immediate_generator
    import core_pkg::*;
#(
    parameter int unsigned XLEN = 32
) (
    input  logic [31:7]     instruction_i,
    input  imm_fmt_e        format_i,
    output logic [XLEN-1:0] immediate_o
);

    logic [31:0] imm32;

    always_comb begin
        imm32 = '0;
        unique case (format_i)
            FMT_I:   imm32 = {{20{instruction_i[31]}}, instruction_i[31:20]};
            FMT_S:   imm32 = {{20{instruction_i[31]}}, instruction_i[31:25], instruction_i[11:7]};
            FMT_B:   imm32 = {{19{instruction_i[31]}}, instruction_i[31], instruction_i[7],
                              instruction_i[30:25], instruction_i[11:8], 1'b0};
            FMT_U:   imm32 = {instruction_i[31:12], 12'b0};
            FMT_J:   imm32 = {{11{instruction_i[31]}}, instruction_i[31], instruction_i[19:12],
                              instruction_i[20], instruction_i[30:21], 1'b0};
            default: imm32 = '0;
        endcase
    end

    assign immediate_o = XLEN'($signed(imm32));

endmodule

// File: rtl/decode_stage.sv
// RV32I decode stage: single output slot aligned with the register file's 1-cycle read,
// with a load-use stall that waits one extra cycle for write-before-read data to land.
module decode_stage
    import core_pkg::*;
#(
    parameter int unsigned XLEN           = 32,
    parameter int unsigned REG_ADDR_WIDTH = 5
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      fetch_valid,
    input  logic [31:0]               fetch_instruction,
    input  logic [XLEN-1:0]           fetch_pc,
    output logic                      fetch_ready,
    output logic [REG_ADDR_WIDTH-1:0] register_read_address_a,
    output logic [REG_ADDR_WIDTH-1:0] register_read_address_b,
    input  logic                      ex_load_pending,
    input  logic [REG_ADDR_WIDTH-1:0] ex_load_rd,
    output logic                      decode_valid,
    input  logic                      decode_ready,
    output logic [XLEN-1:0]           decode_pc,
    output logic [REG_ADDR_WIDTH-1:0] decode_rd,
    output logic [REG_ADDR_WIDTH-1:0] decode_rs1,
    output logic [REG_ADDR_WIDTH-1:0] decode_rs2,
    output logic [2:0]                decode_funct3,
    output logic                      decode_funct7_bit5,
    output logic [3:0]                decode_op_class,
    output logic [XLEN-1:0]           decode_immediate,
    output logic                      decode_illegal
);

    op_info_t                  info_c;
    logic [XLEN-1:0]           imm_c;
    logic [REG_ADDR_WIDTH-1:0] f_rs1_c, f_rs2_c, f_rd_c;
    logic                      hazard_c, fire_c, accept_c;

    logic                      slot_valid_q, slot_valid_d;
    logic                      hazard_hold_q, hazard_hold_d;
    logic [XLEN-1:0]           pc_q, pc_d, imm_q, imm_d;
    logic [REG_ADDR_WIDTH-1:0] rd_q, rd_d, rs1_q, rs1_d, rs2_q, rs2_d;
    logic [2:0]                funct3_q, funct3_d;
    logic                      f7b5_q, f7b5_d, illegal_q, illegal_d;
    logic                      uses_rs1_q, uses_rs1_d, uses_rs2_q, uses_rs2_d;
    op_class_e                 op_class_q, op_class_d;

    assign info_c  = classify(fetch_instruction[6:0]);
    assign f_rs1_c = REG_ADDR_WIDTH'(fetch_instruction[19:15]);
    assign f_rs2_c = REG_ADDR_WIDTH'(fetch_instruction[24:20]);
    assign f_rd_c  = REG_ADDR_WIDTH'(fetch_instruction[11:7]);

    immediate_generator #(.XLEN(XLEN)) u_imm (
        .instruction_i (fetch_instruction[31:7]),
        .format_i      (info_c.fmt),
        .immediate_o   (imm_c)
    );

    assign hazard_c = slot_valid_q && ex_load_pending && (ex_load_rd != '0) &&
                      ((uses_rs1_q && (ex_load_rd == rs1_q)) ||
                       (uses_rs2_q && (ex_load_rd == rs2_q)));

    assign decode_valid = slot_valid_q && !hazard_c && !hazard_hold_q;
    assign fire_c       = decode_valid && decode_ready;
    assign fetch_ready  = rst && (!slot_valid_q || fire_c);
    assign accept_c     = fetch_valid && fetch_ready;

    // Held slot keeps re-reading so writebacks during a stall reach the read ports.
    assign register_read_address_a = accept_c ? f_rs1_c : rs1_q;
    assign register_read_address_b = accept_c ? f_rs2_c : rs2_q;

    always_comb begin
        slot_valid_d  = slot_valid_q;
        hazard_hold_d = hazard_c;
        pc_d          = pc_q;
        imm_d         = imm_q;
        rd_d          = rd_q;
        rs1_d         = rs1_q;
        rs2_d         = rs2_q;
        funct3_d      = funct3_q;
        f7b5_d        = f7b5_q;
        illegal_d     = illegal_q;
        uses_rs1_d    = uses_rs1_q;
        uses_rs2_d    = uses_rs2_q;
        op_class_d    = op_class_q;
        if (accept_c) begin
            slot_valid_d = 1'b1;
            pc_d         = fetch_pc;
            imm_d        = imm_c;
            rd_d         = info_c.writes_rd ? f_rd_c : '0;
            rs1_d        = f_rs1_c;
            rs2_d        = f_rs2_c;
            funct3_d     = fetch_instruction[14:12];
            f7b5_d       = fetch_instruction[30];
            illegal_d    = (info_c.op_class == OP_ILLEGAL);
            uses_rs1_d   = info_c.uses_rs1;
            uses_rs2_d   = info_c.uses_rs2;
            op_class_d   = info_c.op_class;
        end else if (fire_c) begin
            slot_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            slot_valid_q  <= 1'b0;
            hazard_hold_q <= 1'b0;
            pc_q          <= '0;
            imm_q         <= '0;
            rd_q          <= '0;
            rs1_q         <= '0;
            rs2_q         <= '0;
            funct3_q      <= '0;
            f7b5_q        <= 1'b0;
            illegal_q     <= 1'b0;
            uses_rs1_q    <= 1'b0;
            uses_rs2_q    <= 1'b0;
            op_class_q    <= OP_ALU;
        end else begin
            slot_valid_q  <= slot_valid_d;
            hazard_hold_q <= hazard_hold_d;
            pc_q          <= pc_d;
            imm_q         <= imm_d;
            rd_q          <= rd_d;
            rs1_q         <= rs1_d;
            rs2_q         <= rs2_d;
            funct3_q      <= funct3_d;
            f7b5_q        <= f7b5_d;
            illegal_q     <= illegal_d;
            uses_rs1_q    <= uses_rs1_d;
            uses_rs2_q    <= uses_rs2_d;
            op_class_q    <= op_class_d;
        end
    end

    assign decode_pc          = pc_q;
    assign decode_rd          = rd_q;
    assign decode_rs1         = rs1_q;
    assign decode_rs2         = rs2_q;
    assign decode_funct3      = funct3_q;
    assign decode_funct7_bit5 = f7b5_q;
    assign decode_op_class    = 4'(op_class_q);
    assign decode_immediate   = imm_q;
    assign decode_illegal     = illegal_q;

endmodule

// File: tb/tb_decode_stage.sv
// Directed bench for decode_stage: expected decodes are queued on accept and checked on fire.
module tb_decode_stage;
    import core_pkg::*;

    localparam int unsigned XLEN = 32;
    localparam int unsigned RAW  = 5;

    logic            clk = 1'b0;
    logic            rst;
    logic            fetch_valid;
    logic [31:0]     fetch_instruction;
    logic [XLEN-1:0] fetch_pc;
    logic            fetch_ready;
    logic [RAW-1:0]  register_read_address_a, register_read_address_b;
    logic            ex_load_pending;
    logic [RAW-1:0]  ex_load_rd;
    logic            decode_valid;
    logic            decode_ready;
    logic [XLEN-1:0] decode_pc;
    logic [RAW-1:0]  decode_rd, decode_rs1, decode_rs2;
    logic [2:0]      decode_funct3;
    logic            decode_funct7_bit5;
    logic [3:0]      decode_op_class;
    logic [XLEN-1:0] decode_immediate;
    logic            decode_illegal;

    always #5 clk = ~clk;

    decode_stage #(.XLEN(XLEN), .REG_ADDR_WIDTH(RAW)) dut (
        .clk                     (clk),
        .rst                     (rst),
        .fetch_valid             (fetch_valid),
        .fetch_instruction       (fetch_instruction),
        .fetch_pc                (fetch_pc),
        .fetch_ready             (fetch_ready),
        .register_read_address_a (register_read_address_a),
        .register_read_address_b (register_read_address_b),
        .ex_load_pending         (ex_load_pending),
        .ex_load_rd              (ex_load_rd),
        .decode_valid            (decode_valid),
        .decode_ready            (decode_ready),
        .decode_pc               (decode_pc),
        .decode_rd               (decode_rd),
        .decode_rs1              (decode_rs1),
        .decode_rs2              (decode_rs2),
        .decode_funct3           (decode_funct3),
        .decode_funct7_bit5      (decode_funct7_bit5),
        .decode_op_class         (decode_op_class),
        .decode_immediate        (decode_immediate),
        .decode_illegal          (decode_illegal)
    );

    typedef struct {
        logic [31:0] pc;
        logic [4:0]  rd, rs1, rs2;
        logic [2:0]  f3;
        logic        f7;
        logic [3:0]  cls;
        logic [31:0] imm;
        logic        ill;
    } exp_t;

    exp_t sb_q[$];
    exp_t offer_exp;
    int   vectors     = 0;
    int   miscompares = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    task automatic offer(input logic [31:0] instr, input logic [31:0] pc,
                         input logic [4:0] rd, input logic [4:0] rs1, input logic [4:0] rs2,
                         input logic [2:0] f3, input logic f7, input op_class_e cls,
                         input logic [31:0] imm, input logic ill);
        fetch_valid       = 1'b1;
        fetch_instruction = instr;
        fetch_pc          = pc;
        offer_exp.pc  = pc;
        offer_exp.rd  = rd;
        offer_exp.rs1 = rs1;
        offer_exp.rs2 = rs2;
        offer_exp.f3  = f3;
        offer_exp.f7  = f7;
        offer_exp.cls = 4'(cls);
        offer_exp.imm = imm;
        offer_exp.ill = ill;
    endtask

    // Pop/compare on fire, push on accept, then advance one clock.
    task automatic cyc();
        exp_t e;
        #1;
        if (rst && decode_valid && decode_ready) begin
            chk("sb_entry_present", 32'(sb_q.size() != 0), 32'd1);
            if (sb_q.size() != 0) begin
                e = sb_q.pop_front();
                chk("out_pc",  decode_pc,                 e.pc);
                chk("out_rd",  32'(decode_rd),            32'(e.rd));
                chk("out_rs1", 32'(decode_rs1),           32'(e.rs1));
                chk("out_rs2", 32'(decode_rs2),           32'(e.rs2));
                chk("out_f3",  32'(decode_funct3),        32'(e.f3));
                chk("out_f7",  32'(decode_funct7_bit5),   32'(e.f7));
                chk("out_cls", 32'(decode_op_class),      32'(e.cls));
                chk("out_imm", decode_immediate,          e.imm);
                chk("out_ill", 32'(decode_illegal),       32'(e.ill));
            end
        end
        if (fetch_valid && fetch_ready) sb_q.push_back(offer_exp);
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b0; fetch_valid = 1'b0; fetch_instruction = '0; fetch_pc = '0;
        ex_load_pending = 1'b0; ex_load_rd = '0; decode_ready = 1'b1;

        // Reset with an instruction offered: nothing may be accepted.
        offer(32'hFFD08293, 32'h100, 5'd5, 5'd1, 5'd29, 3'd0, 1'b1, OP_ALU_IMM, 32'hFFFFFFFD, 1'b0);
        @(posedge clk); #1;
        @(posedge clk); #1;
        chk("rst_fetch_ready",  32'(fetch_ready), 32'd0);
        chk("rst_decode_valid", 32'(decode_valid), 32'd0);
        chk("rst_rd",           32'(decode_rd), 32'd0);
        chk("rst_imm",          decode_immediate, 32'd0);
        chk("rst_pc",           decode_pc, 32'd0);

        // ADDI x5,x1,-3
        rst = 1'b1; #1;
        chk("addi_fetch_ready", 32'(fetch_ready), 32'd1);
        chk("addi_addr_a",      32'(register_read_address_a), 32'd1);
        chk("addi_addr_b",      32'(register_read_address_b), 32'd29);
        cyc();
        fetch_valid = 1'b0; #1;
        chk("addi_valid", 32'(decode_valid), 32'd1);
        cyc();

        // Back-to-back ADD, SUB, SW
        offer(32'h002303B3, 32'h104, 5'd7, 5'd6, 5'd2, 3'd0, 1'b0, OP_ALU, 32'd0, 1'b0);
        cyc();
        offer(32'h40520433, 32'h108, 5'd8, 5'd4, 5'd5, 3'd0, 1'b1, OP_ALU, 32'd0, 1'b0);
        #1; chk("b2b_ready_sub", 32'(fetch_ready), 32'd1);
        cyc();
        offer(32'h0021A423, 32'h10C, 5'd0, 5'd3, 5'd2, 3'd2, 1'b0, OP_STORE, 32'd8, 1'b0);
        #1; chk("b2b_ready_sw", 32'(fetch_ready), 32'd1);
        cyc();
        fetch_valid = 1'b0; #1;
        chk("sw_valid", 32'(decode_valid), 32'd1);
        cyc();

        // BEQ x1,x2,-4 held for 3 cycles by execute back-pressure
        decode_ready = 1'b0;
        offer(32'hFE208EE3, 32'h110, 5'd0, 5'd1, 5'd2, 3'd0, 1'b1, OP_BRANCH, 32'hFFFFFFFC, 1'b0);
        cyc();
        offer(32'h001000EF, 32'h114, 5'd1, 5'd0, 5'd1, 3'd0, 1'b0, OP_JAL, 32'h800, 1'b0);
        for (int i = 0; i < 3; i++) begin
            #1;
            chk("stall_fetch_ready", 32'(fetch_ready), 32'd0);
            chk("stall_valid",       32'(decode_valid), 32'd1);
            chk("stall_addr_a",      32'(register_read_address_a), 32'd1);
            chk("stall_addr_b",      32'(register_read_address_b), 32'd2);
            chk("stall_pc",          decode_pc, 32'h110);
            cyc();
        end
        decode_ready = 1'b1; #1;
        chk("unstall_ready", 32'(fetch_ready), 32'd1);
        cyc();
        fetch_valid = 1'b0;
        cyc();

        // Load-use on ADD x7,x6,x2: rs1 then rs2 match, then one extra hold cycle
        ex_load_pending = 1'b1; ex_load_rd = 5'd6;
        offer(32'h002303B3, 32'h120, 5'd7, 5'd6, 5'd2, 3'd0, 1'b0, OP_ALU, 32'd0, 1'b0);
        cyc();
        fetch_valid = 1'b0; #1;
        chk("haz_rs1_valid", 32'(decode_valid), 32'd0);
        chk("haz_ready",     32'(fetch_ready), 32'd0);
        cyc();
        ex_load_rd = 5'd2; #1;
        chk("haz_rs2_valid", 32'(decode_valid), 32'd0);
        cyc();
        ex_load_pending = 1'b0; #1;
        chk("hold_valid_n", 32'(decode_valid), 32'd0);
        cyc();
        #1; chk("release_valid_n1", 32'(decode_valid), 32'd1);
        cyc();

        // ex_load_rd = x0 never stalls
        ex_load_pending = 1'b1; ex_load_rd = 5'd0;
        offer(32'h000003B3, 32'h130, 5'd7, 5'd0, 5'd0, 3'd0, 1'b0, OP_ALU, 32'd0, 1'b0);
        cyc();
        fetch_valid = 1'b0; #1;
        chk("x0_no_stall", 32'(decode_valid), 32'd1);
        cyc();

        // LUI x6: raw rs1 field is 8, but LUI reads no registers
        ex_load_rd = 5'd8;
        offer(32'h12345337, 32'h134, 5'd6, 5'd8, 5'd3, 3'd5, 1'b0, OP_LUI, 32'h12345000, 1'b0);
        cyc();
        fetch_valid = 1'b0; #1;
        chk("lui_no_stall", 32'(decode_valid), 32'd1);
        cyc();
        ex_load_pending = 1'b0;

        // Opcode 0x7F with rd field 31: illegal, rd forced to 0
        offer(32'h00000FFF, 32'h138, 5'd0, 5'd0, 5'd0, 3'd0, 1'b0, OP_ILLEGAL, 32'd0, 1'b1);
        cyc();
        fetch_valid = 1'b0; #1;
        chk("ill_valid", 32'(decode_valid), 32'd1);
        chk("ill_flag",  32'(decode_illegal), 32'd1);
        cyc();

        // Reset while stalled drops the held instruction
        decode_ready = 1'b0;
        offer(32'h002303B3, 32'h140, 5'd7, 5'd6, 5'd2, 3'd0, 1'b0, OP_ALU, 32'd0, 1'b0);
        cyc();
        fetch_valid = 1'b0; #1;
        chk("pre_rst_valid", 32'(decode_valid), 32'd1);
        rst = 1'b0;
        cyc();
        chk("mid_rst_valid", 32'(decode_valid), 32'd0);
        chk("mid_rst_ready", 32'(fetch_ready), 32'd0);
        chk("mid_rst_pc",    decode_pc, 32'd0);
        sb_q.delete();
        rst = 1'b1; decode_ready = 1'b1; #1;
        chk("post_rst_ready", 32'(fetch_ready), 32'd1);
        chk("post_rst_valid", 32'(decode_valid), 32'd0);
        cyc();
        chk("sb_drained", 32'(sb_q.size()), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
